// File: rtl/store_unit_pkg.sv
// store_unit_pkg: store opcodes and the buffered entry layout shared by the store path.
package store_unit_pkg;
    localparam int ST_OP_LENGTH = 2;
    typedef enum logic [ST_OP_LENGTH-1:0] {
        ST_OP_NONE = 2'b00,
        ST_OP_SB   = 2'b01,
        ST_OP_SH   = 2'b10,
        ST_OP_SW   = 2'b11
    } st_op_e;
    typedef struct packed {
        logic [29:0] word_addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } entry_t;
endpackage

// File: rtl/store_align.sv
// store_align: combinational lane mapper turning a store request into word address, replicated data and byte enables.
module store_align
    import store_unit_pkg::*;
(
    input  logic [ST_OP_LENGTH-1:0] op,
    input  logic [31:0]             addr,
    input  logic [31:0]             data,
    output logic [29:0]             word_addr,
    output logic [31:0]             wdata,
    output logic [3:0]              be,
    output logic                    misaligned
);
    assign word_addr  = addr[31:2];
    assign misaligned = (op == ST_OP_SH && addr[0]) || (op == ST_OP_SW && addr[1:0] != 2'b00);
    assign wdata = op == ST_OP_SB ? {4{data[7:0]}} :
                   op == ST_OP_SH ? {2{data[15:0]}} : data;
    assign be = op == ST_OP_SB ? 4'b0001 << addr[1:0] :
                op == ST_OP_SH ? (addr[1] ? 4'b1100 : 4'b0011) :
                op == ST_OP_SW ? 4'b1111 : 4'b0000;
endmodule

// File: rtl/store_unit.sv
// store_unit: buffers aligned stores in a circular FIFO and drains them to data memory over valid/ready.
module store_unit
    import store_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      st_valid,
    output logic                      st_ready,
    input  logic [ST_OP_LENGTH-1:0]   st_op,
    input  logic [31:0]               st_addr,
    input  logic [31:0]               st_data,
    output logic                      misalign,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic [31:0]               mem_addr,
    output logic [31:0]               mem_wdata,
    output logic [3:0]                mem_be,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int AW = $clog2(DEPTH);
    entry_t          fifo [DEPTH];
    entry_t          in_entry, head;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            mis, accept, push, pop;
    store_align u_align (
        .op         (st_op),
        .addr       (st_addr),
        .data       (st_data),
        .word_addr  (in_entry.word_addr),
        .wdata      (in_entry.wdata),
        .be         (in_entry.be),
        .misaligned (mis)
    );
    assign st_ready  = count != (AW+1)'(DEPTH);
    assign mem_valid = count != '0;
    assign accept    = st_valid && st_ready;
    assign push      = accept && st_op != ST_OP_NONE && !mis;
    assign pop       = mem_valid && mem_ready;
    assign head      = fifo[rd_ptr];
    // Outputs are zeroed while empty so stale entries never appear on the bus.
    assign mem_addr  = mem_valid ? {head.word_addr, 2'b00} : '0;
    assign mem_wdata = mem_valid ? head.wdata : '0;
    assign mem_be    = mem_valid ? head.be : '0;
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= in_entry;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            misalign <= 1'b0;
        end else begin
            misalign <= accept && mis;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop) count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);
        end
    end
endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed scenario tests for store_unit with DEPTH=2.
module tb_store_unit;
    logic        clk = 0, rst = 1, st_valid = 0, mem_ready = 0;
    logic [1:0]  st_op = 0;
    logic [31:0] st_addr = 0, st_data = 0;
    logic        st_ready, misalign, mem_valid;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [1:0]  count;
    int errors = 0, checks = 0;

    store_unit #(.DEPTH(2)) dut (
        .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready), .st_op(st_op),
        .st_addr(st_addr), .st_data(st_data), .misalign(misalign), .mem_valid(mem_valid),
        .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        st_valid = v; st_op = op; st_addr = a; st_data = d;
    endtask

    task automatic test_reset();
        rst = 1; step(); step(); rst = 0;
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got %b exp 0", mem_valid); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b exp 0", misalign); end
        checks++; if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin errors++; $display("FAIL reset_bus got %h/%h/%b exp 0", mem_addr, mem_wdata, mem_be); end
        checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL reset_st_ready got %b exp 1", st_ready); end
    endtask

    task automatic test_sb();
        mem_ready = 1;
        drive(1, 2'b01, 32'h0000_1003, 32'hAABB_CC5A); step(); drive(0, 0, 0, 0);
        checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL sb_valid got %b exp 1", mem_valid); end
        checks++; if (mem_addr !== 32'h1000) begin errors++; $display("FAIL sb_addr got %h exp 00001000", mem_addr); end
        checks++; if (mem_wdata !== 32'h5A5A5A5A) begin errors++; $display("FAIL sb_wdata got %h exp 5a5a5a5a", mem_wdata); end
        checks++; if (mem_be !== 4'b1000) begin errors++; $display("FAIL sb_be got %b exp 1000", mem_be); end
        step();
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL sb_drained got %0d exp 0", count); end
        drive(1, 2'b01, 32'h0000_1001, 32'h0000_0077); step(); drive(0, 0, 0, 0);
        checks++; if (mem_be !== 4'b0010 || mem_wdata !== 32'h77777777) begin errors++; $display("FAIL sb_lane1 got %b/%h exp 0010/77777777", mem_be, mem_wdata); end
        step();
    endtask

    task automatic test_sh();
        mem_ready = 1;
        drive(1, 2'b10, 32'h0000_2002, 32'h1234_9ABC); step(); drive(0, 0, 0, 0);
        checks++; if (mem_wdata !== 32'h9ABC9ABC) begin errors++; $display("FAIL sh_wdata got %h exp 9abc9abc", mem_wdata); end
        checks++; if (mem_be !== 4'b1100 || mem_addr !== 32'h2000) begin errors++; $display("FAIL sh_be_addr got %b/%h exp 1100/00002000", mem_be, mem_addr); end
        step();
        drive(1, 2'b10, 32'h0000_2000, 32'h0000_BEEF); step(); drive(0, 0, 0, 0);
        checks++; if (mem_be !== 4'b0011) begin errors++; $display("FAIL sh_low_be got %b exp 0011", mem_be); end
        step();
        drive(1, 2'b10, 32'h0000_2001, 32'h1234_9ABC); step(); drive(0, 0, 0, 0);
        checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL sh_misalign_pulse got %b exp 1", misalign); end
        checks++; if (count !== 2'd0 || mem_valid !== 1'b0) begin errors++; $display("FAIL sh_misalign_dropped got count %0d valid %b exp 0/0", count, mem_valid); end
        step();
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL sh_misalign_one_cycle got %b exp 0", misalign); end
        drive(1, 2'b11, 32'h0000_3002, 32'h5555_5555); step(); drive(0, 0, 0, 0);
        checks++; if (misalign !== 1'b1 || count !== 2'd0) begin errors++; $display("FAIL sw_misalign got %b/%0d exp 1/0", misalign, count); end
        step();
    endtask

    task automatic test_back_to_back();
        mem_ready = 0;
        drive(1, 2'b11, 32'h100, 32'h11111111); step();
        checks++; if (count !== 2'd1) begin errors++; $display("FAIL b2b_count1 got %0d exp 1", count); end
        drive(1, 2'b11, 32'h104, 32'h22222222); step();
        checks++; if (count !== 2'd2 || st_ready !== 1'b0) begin errors++; $display("FAIL b2b_full got %0d/%b exp 2/0", count, st_ready); end
        drive(1, 2'b11, 32'h108, 32'h33333333); step();
        checks++; if (count !== 2'd2 || mem_wdata !== 32'h11111111 || mem_addr !== 32'h100) begin errors++; $display("FAIL b2b_stall got %0d/%h/%h exp 2/11111111/00000100", count, mem_wdata, mem_addr); end
        mem_ready = 1;
        checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %b exp 0", st_ready); end
        step();
        checks++; if (count !== 2'd1 || st_ready !== 1'b1 || mem_wdata !== 32'h22222222) begin errors++; $display("FAIL b2b_pop1 got %0d/%b/%h exp 1/1/22222222", count, st_ready, mem_wdata); end
        mem_ready = 0; step(); drive(0, 0, 0, 0);
        checks++; if (count !== 2'd2) begin errors++; $display("FAIL b2b_third_in got %0d exp 2", count); end
        mem_ready = 1; step();
        checks++; if (mem_wdata !== 32'h33333333 || mem_addr !== 32'h108) begin errors++; $display("FAIL b2b_order got %h/%h exp 33333333/00000108", mem_wdata, mem_addr); end
        step();
        checks++; if (count !== 2'd0 || mem_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %0d/%b exp 0/0", count, mem_valid); end
    endtask

    task automatic test_simultaneous();
        mem_ready = 0;
        drive(1, 2'b11, 32'h0, 32'h100); step();
        mem_ready = 1;
        for (int i = 0; i < 10; i++) begin
            drive(1, 2'b11, 32'(4 * (i + 1)), 32'(32'h100 + i + 1));
            checks++; if (mem_wdata !== 32'(32'h100 + i) || mem_addr !== 32'(4 * i)) begin errors++; $display("FAIL simul_head%0d got %h/%h exp %h/%h", i, mem_wdata, mem_addr, 32'h100 + i, 4 * i); end
            step();
            checks++; if (count !== 2'd1) begin errors++; $display("FAIL simul_count%0d got %0d exp 1", i, count); end
        end
        drive(0, 0, 0, 0);
        checks++; if (mem_wdata !== 32'h10A) begin errors++; $display("FAIL simul_last got %h exp 0000010a", mem_wdata); end
        step();
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL simul_drain got %0d exp 0", count); end
    endtask

    task automatic test_reset_mid();
        mem_ready = 0;
        drive(1, 2'b11, 32'h200, 32'hA); step();
        drive(1, 2'b11, 32'h204, 32'hB); step();
        checks++; if (count !== 2'd2 || mem_valid !== 1'b1) begin errors++; $display("FAIL rstmid_full got %0d/%b exp 2/1", count, mem_valid); end
        rst = 1; mem_ready = 1; drive(1, 2'b11, 32'h208, 32'hC); step();
        rst = 0; drive(0, 0, 0, 0);
        checks++; if (count !== 2'd0 || mem_valid !== 1'b0 || mem_be !== 4'b0) begin errors++; $display("FAIL rstmid_cleared got %0d/%b/%b exp 0/0/0000", count, mem_valid, mem_be); end
        step();
        checks++; if (mem_valid !== 1'b0 || st_ready !== 1'b1) begin errors++; $display("FAIL rstmid_idle got %b/%b exp 0/1", mem_valid, st_ready); end
    endtask

    task automatic test_none();
        drive(1, 2'b00, 32'h301, 32'hFFFF_FFFF);
        checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL none_ready got %b exp 1", st_ready); end
        step(); drive(0, 0, 0, 0);
        checks++; if (count !== 2'd0 || misalign !== 1'b0 || mem_valid !== 1'b0) begin errors++; $display("FAIL none_dropped got %0d/%b/%b exp 0/0/0", count, misalign, mem_valid); end
    endtask

    initial begin
        test_reset();
        test_sb();
        test_sh();
        test_back_to_back();
        test_simultaneous();
        test_reset_mid();
        test_none();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
